xalu_ise_dispatch: RTL
======================

// Module: xalu_ise_dispatch
// PURPOSE
// Core-side issuer for the xalu_ise custom-instruction datapath. Accepts one decoded
// custom-0..3 instruction at a time from the core pipeline over a valid/ready request,
// registers it, drives the ise_* request bus, and captures ise_out on ise_oval.
// Returns the result and rd tag over a valid/ready response. A missing ise_oval
// within MAX_WAIT cycles is reported as an illegal instruction.
// PARAMETERS
// MAX_WAIT   1   extra EXEC cycles allowed after the first before timeout (0 = single-cycle)
// TAG_W      5   width of rd tag carried request->response
// PORTS
// ise_clk      in   1     clock, all state on rising edge
// ise_rst      in   1     asynchronous, active-low reset
// req_valid    in   1     core presents instruction
// req_ready    out  1     dispatcher accepts (req_valid & req_ready = accept)
// req_fn       in   5     opcode select; [1:0] = CUSTOM_0..3
// req_imm      in   7     funct7 field
// req_rs1      in   64    operand 1
// req_rs2      in   64    operand 2
// req_rd       in   TAG_W destination tag
// ise_val      out  1     request valid to xalu_ise
// ise_fn       out  5     registered req_fn
// ise_imm      out  7     registered req_imm
// ise_in1      out  64    registered req_rs1
// ise_in2      out  64    registered req_rs2
// ise_oval     in   1     xalu result valid
// ise_out      in   64    xalu result
// rsp_valid    out  1     response available
// rsp_ready    in   1     core consumes response
// rsp_data     out  64    captured result (0 when illegal)
// rsp_rd       out  TAG_W tag of the completed instruction
// rsp_illegal  out  1     no ise_oval within timeout
// busy         out  1     state != IDLE
// perf_clr     in   1     synchronous clear of perf counters
// perf_issued  out  32    instructions completed
// perf_illegal out  32    instructions completed illegal
// BEHAVIOUR
// - Reset (ise_rst=0, async): state=IDLE; every output 0; operand/result regs 0; wait_cnt 0.
// - States: IDLE, EXEC, RESP.
//   IDLE: req_ready=1. Accept -> latch fn/imm/rs1/rs2/rd, wait_cnt=0, go EXEC.
//   EXEC: ise_val=1, ise_* = latched values. ise_oval=1 -> rsp_data=ise_out,
//     rsp_illegal=0, go RESP. Else wait_cnt==MAX_WAIT -> rsp_data=0, rsp_illegal=1, go RESP.
//     Else wait_cnt++. wait_cnt width $clog2(MAX_WAIT+1), min 1 bit.
//   RESP: rsp_valid=1, rsp_* stable until rsp_ready. rsp_ready=1 -> if req_valid,
//     accept new instruction and go EXEC (back-to-back), else IDLE.
// - req_ready = (IDLE) | (RESP & rsp_ready); combinational from rsp_ready only.
// - Outside EXEC: ise_val=0 and ise_fn/imm/in1/in2 driven 0; ise_oval/ise_out ignored.
// - Latency: accept in cycle N -> ise_val in N+1; oval in N+1 -> rsp_valid in N+2.
//   Sustained throughput 1 instr / 2 cycles with rsp_ready held high.
// - ise_oval in same cycle as timeout: result wins (legal).
// - req_* changes while not accepted have no effect; no request is dropped or duplicated.
// CONFIGURATION
// XALU_DISPATCH_PERF_EN defined: perf_issued +1 on each RESP handshake; perf_illegal +1
//   additionally when rsp_illegal. Counters saturate at 32'hFFFF_FFFF. perf_clr=1 forces 0
//   next cycle, overriding a coincident increment. Reset clears both.
// Not defined: counters not built; perf_issued/perf_illegal tied 0; perf_clr ignored.
// Port list identical in both builds.
// TESTING
// 1 Reset mid-EXEC (ise_rst low 1 cycle) -> all outputs 0, busy=0, next req accepted normally.
// 2 req fn=5'b00011 imm=7'h00 rs1=64'h1 rs2=64'h2, xalu returns oval same cycle with
//   ise_out=64'h0000_0002_0000_0001 -> rsp_valid 2 cycles after accept, rsp_data match, rsp_illegal=0, rsp_rd=req_rd.
// 3 Unsupported imm=7'h7F (xalu oval=0), MAX_WAIT=1 -> ise_val high 2 cycles, rsp_illegal=1, rsp_data=0.
// 4 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0, ise_val=0; then 1 -> single handshake.
// 5 Back-to-back: 4 requests, rsp_ready=1 -> 4 responses in order, tags 0..3, 8 cycles total.
// 6 PERF_EN: 3 legal + 1 illegal -> perf_issued=4, perf_illegal=1; perf_clr with completing RESP -> 0.

Source files
------------

// File: rtl/xalu_ise_dispatch_if.sv
// Handshake bundle between the core, the dispatcher and the xalu_ise datapath.
// master = core/xalu side, slave = dispatcher.
interface xalu_ise_dispatch_if #(parameter int TAG_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_fn;
  logic [6:0]       req_imm;
  logic [63:0]      req_rs1;
  logic [63:0]      req_rs2;
  logic [TAG_W-1:0] req_rd;
  logic             ise_val;
  logic [4:0]       ise_fn;
  logic [6:0]       ise_imm;
  logic [63:0]      ise_in1;
  logic [63:0]      ise_in2;
  logic             ise_oval;
  logic [63:0]      ise_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [63:0]      rsp_data;
  logic [TAG_W-1:0] rsp_rd;
  logic             rsp_illegal;

  modport master (
    output req_valid, req_fn, req_imm, req_rs1, req_rs2, req_rd,
    input  req_ready,
    input  ise_val, ise_fn, ise_imm, ise_in1, ise_in2,
    output ise_oval, ise_out,
    input  rsp_valid, rsp_data, rsp_rd, rsp_illegal,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_fn, req_imm, req_rs1, req_rs2, req_rd,
    output req_ready,
    output ise_val, ise_fn, ise_imm, ise_in1, ise_in2,
    input  ise_oval, ise_out,
    output rsp_valid, rsp_data, rsp_rd, rsp_illegal,
    input  rsp_ready
  );
endinterface

// File: rtl/xalu_ise_dispatch.sv
// Core-side issuer for xalu_ise custom instructions: IDLE -> EXEC -> RESP with timeout.
// Optional perf counters built when XALU_DISPATCH_PERF_EN is defined.
module xalu_ise_dispatch #(
  parameter int MAX_WAIT = 1,
  parameter int TAG_W    = 5
) (
  input  logic                 ise_clk,
  input  logic                 ise_rst,
  xalu_ise_dispatch_if.slave   bus,
  output logic                 busy,
  input  logic                 perf_clr,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_illegal
);
  localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  typedef struct packed {
    logic [4:0]       fn;
    logic [6:0]       imm;
    logic [63:0]      rs1;
    logic [63:0]      rs2;
    logic [TAG_W-1:0] rd;
  } op_t;

  state_e         state_q, state_d;
  op_t            op_q, op_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic [63:0]    data_q, data_d;
  logic           ill_q, ill_d;
  logic           in_exec, in_resp, accept, rsp_hs;

  assign in_exec = (state_q == EXEC);
  assign in_resp = (state_q == RESP);
  assign rsp_hs  = in_resp & bus.rsp_ready;
  // Gated by reset so every output reads 0 while reset is held.
  assign bus.req_ready = ise_rst & ((state_q == IDLE) | rsp_hs);
  assign accept  = bus.req_valid & bus.req_ready;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    data_d  = data_q;
    ill_d   = ill_q;
    case (state_q)
      IDLE: ;
      EXEC: begin
        // A result arriving on the timeout cycle still counts as legal.
        if (bus.ise_oval) begin
          data_d  = bus.ise_out;
          ill_d   = 1'b0;
          state_d = RESP;
        end else if (wait_q == WMAX) begin
          data_d  = '0;
          ill_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + WCW'(1);
        end
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      op_d    = '{fn: bus.req_fn, imm: bus.req_imm, rs1: bus.req_rs1,
                  rs2: bus.req_rs2, rd: bus.req_rd};
      wait_d  = '0;
      state_d = EXEC;
    end
  end

  always_ff @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.ise_val     = in_exec;
  assign bus.ise_fn      = in_exec ? op_q.fn  : '0;
  assign bus.ise_imm     = in_exec ? op_q.imm : '0;
  assign bus.ise_in1     = in_exec ? op_q.rs1 : '0;
  assign bus.ise_in2     = in_exec ? op_q.rs2 : '0;
  assign bus.rsp_valid   = in_resp;
  assign bus.rsp_data    = in_resp ? data_q  : '0;
  assign bus.rsp_rd      = in_resp ? op_q.rd : '0;
  assign bus.rsp_illegal = in_resp & ill_q;
  assign busy            = (state_q != IDLE);

`ifdef XALU_DISPATCH_PERF_EN
  logic [31:0] iss_q, illc_q;

  // Clear wins over a coincident increment; both counters saturate.
  always_ff @(posedge ise_clk or negedge ise_rst) begin
    if (!ise_rst) begin
      iss_q  <= '0;
      illc_q <= '0;
    end else if (perf_clr) begin
      iss_q  <= '0;
      illc_q <= '0;
    end else if (rsp_hs) begin
      if (iss_q != '1)           iss_q  <= iss_q + 32'd1;
      if (ill_q && illc_q != '1) illc_q <= illc_q + 32'd1;
    end
  end

  assign perf_issued  = iss_q;
  assign perf_illegal = illc_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign perf_issued     = '0;
  assign perf_illegal    = '0;
`endif
endmodule
